// File: rtl/seg7_scan_driver_if.sv
// Display bus between the display-data selector and the seven-segment scanner.
// Carries the eight digit codes and time-mode flag in, anode/segment drive out.
// Optional SEG7_DIM_EN macro adds the 3-bit bright input.
//
// Ports (signals):
//   disp_time     1 = time mode, HH.MM.SS separators lit
//   dig0..dig7    4-bit digit codes, dig0 is the rightmost digit
//   bright        3-bit brightness (only with SEG7_DIM_EN)
//   an            8 anode enables, an[i] drives digit i
//   seg           7 segments, seg[0]=a .. seg[6]=g
//   dp            decimal-point segment
interface seg7_scan_driver_if;
  logic       disp_time;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [3:0] dig4;
  logic [3:0] dig5;
  logic [3:0] dig6;
  logic [3:0] dig7;
`ifdef SEG7_DIM_EN
  logic [2:0] bright;
`endif
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  // Data source side: drives digit data, observes the display drive.
  modport master (
    output disp_time, dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7,
`ifdef SEG7_DIM_EN
    output bright,
`endif
    input  an, seg, dp
  );

  // Scanner side.
  modport slave (
    input  disp_time, dig0, dig1, dig2, dig3, dig4, dig5, dig6, dig7,
`ifdef SEG7_DIM_EN
    input  bright,
`endif
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexes eight 4-bit digit codes onto an 8-digit common-anode
//          seven-segment display, with dead time at the start of each digit slot.
// Latency: an/seg/dp registered, 1 cycle after slot position; new digit data is
//          latched at frame start and shows within 8*DIV_CNT+1 cycles.
// Backpressure: none; free-running scanner, inputs are sampled once per frame.
//
// Ports:
//   clk     system clock
//   arstn   asynchronous active-low reset
//   bus     seg7_scan_driver_if.slave (digit codes, disp_time, an/seg/dp)
// Parameters: DIV_CNT (cycles per slot, > BLANK_CNT), BLANK_CNT (dead-time
//   cycles per slot, 0 = none), ACTIVE_LOW (1 = an/seg/dp active-low).
// Optional macro SEG7_DIM_EN: adds bus.bright; the anode is lit only while
//   slot_cnt[2:0] <= bright outside the dead time (requires DIV_CNT >= 8).
module seg7_scan_driver #(
  parameter int DIV_CNT    = 20000,
  parameter int BLANK_CNT  = 200,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                arstn,
  seg7_scan_driver_if.slave   bus
);

  // DIV_CNT of 1 would give a zero-width counter; keep at least one bit.
  localparam int             CW        = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
  localparam logic [CW-1:0]  SLOT_LAST = CW'(DIV_CNT - 1);
  // Level that means "off" on every output pin.
  localparam logic           INACT     = (ACTIVE_LOW != 0);

  // Active-high segment pattern, bit order g..a.
  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'b0111111;
      4'h1:    pat = 7'b0000110;
      4'h2:    pat = 7'b1011011;
      4'h3:    pat = 7'b1001111;
      4'h4:    pat = 7'b1100110;
      4'h5:    pat = 7'b1101101;
      4'h6:    pat = 7'b1111101;
      4'h7:    pat = 7'b0000111;
      4'h8:    pat = 7'b1111111;
      4'h9:    pat = 7'b1101111;
      4'hA:    pat = 7'b1000000;  // '-'
      4'hB:    pat = 7'b1110110;  // 'H'
      4'hC:    pat = 7'b0111001;  // 'C'
      4'hD:    pat = 7'b1111001;  // 'E'
      4'hE:    pat = 7'b1100011;  // degree sign
      default: pat = 7'b0000000;  // blank
    endcase
    return pat;
  endfunction

  logic [CW-1:0] r_slot_cnt;
  logic [2:0]    r_idx;
  logic [3:0]    r_dig [8];
  logic          r_time;
  logic [7:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_slot_last;
  logic          w_frame_start;
  logic          w_blank;
  logic          w_on;
  logic [7:0]    w_an_hot;
  logic [6:0]    w_seg_hi;
  logic          w_sep_pos;

  assign w_slot_last   = (r_slot_cnt == SLOT_LAST);
  assign w_frame_start = w_slot_last && (r_idx == 3'd7);

  // Dead-time window; with BLANK_CNT = 0 the compare would be constant-false.
  generate
    if (BLANK_CNT > 0) begin : g_blank
      assign w_blank = (r_slot_cnt < CW'(BLANK_CNT));
    end else begin : g_noblank
      assign w_blank = 1'b0;
    end
  endgenerate

`ifdef SEG7_DIM_EN
  // PWM within the slot: bright is live, not shadowed, so dimming reacts at once.
  logic [2:0] w_slot_lo;
  assign w_slot_lo = 3'(r_slot_cnt);
  assign w_on      = !w_blank && (w_slot_lo <= bus.bright);
`else
  assign w_on      = !w_blank;
`endif

  assign w_an_hot  = 8'd1 << r_idx;
  assign w_seg_hi  = f_decode(r_dig[r_idx]);
  // Digits 2 and 4 carry the dots that form HH.MM.SS.
  assign w_sep_pos = (r_idx == 3'd2) || (r_idx == 3'd4);

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_slot_cnt <= '0;
      r_idx      <= 3'd0;
    end else if (w_slot_last) begin
      r_slot_cnt <= '0;
      r_idx      <= r_idx + 3'd1;
    end else begin
      r_slot_cnt <= r_slot_cnt + CW'(1);
    end
  end

  // Shadow registers: loaded only at frame start so a refresh never tears.
  // Reset value 4'hF is the blank code, so the first frame is dark.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      for (int k = 0; k < 8; k++) r_dig[k] <= 4'hF;
      r_time <= 1'b0;
    end else if (w_frame_start) begin
      r_dig[0] <= bus.dig0;
      r_dig[1] <= bus.dig1;
      r_dig[2] <= bus.dig2;
      r_dig[3] <= bus.dig3;
      r_dig[4] <= bus.dig4;
      r_dig[5] <= bus.dig5;
      r_dig[6] <= bus.dig6;
      r_dig[7] <= bus.dig7;
      r_time   <= bus.disp_time;
    end
  end

  // Output registers: all three updated from the same slot/idx so the pins
  // stay coherent. XOR with INACT maps active-high patterns to pin polarity.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_an  <= {8{INACT}};
      r_seg <= {7{INACT}};
      r_dp  <= INACT;
    end else begin
      r_an  <= w_on    ? (w_an_hot ^ {8{INACT}}) : {8{INACT}};
      r_seg <= w_blank ? {7{INACT}} : (w_seg_hi ^ {7{INACT}});
      r_dp  <= (w_on && r_time && w_sep_pos) ? !INACT : INACT;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule
